// File: rtl/hilo_muldiv_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : hilo_muldiv_sequencer_if
// Purpose  : EX-stage <-> HI/LO multiply/divide sequencer handshake bundle.
//            master = pipeline side, slave = sequencer side.
// Revision : 1.0  initial release
// ============================================================================
interface hilo_muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [3:0]       Op;
  logic [WIDTH-1:0] OpA;
  logic [WIDTH-1:0] OpB;
  logic             ReadHiLo;
  logic             HiLoSel;
  logic [WIDTH-1:0] HiLoOut;
  logic             Busy;
  logic             Stall;
  logic             Done;
  logic             DivByZero;

  modport master (
    output Start, Op, OpA, OpB, ReadHiLo, HiLoSel,
    input  HiLoOut, Busy, Stall, Done, DivByZero
  );

  modport slave (
    input  Start, Op, OpA, OpB, ReadHiLo, HiLoSel,
    output HiLoOut, Busy, Stall, Done, DivByZero
  );
endinterface
`default_nettype wire

// File: rtl/hilo_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : hilo_muldiv_sequencer
// Purpose  : Owns the MIPS HI/LO pair. Runs MULT/MULTU/MADD/MSUB through a
//            WIDTH-iteration shift-add engine and DIV/DIVU through a
//            restoring divider; MTHI/MTLO write in a single edge. Stalls the
//            pipeline when it touches HI/LO while the engine is busy.
// Revision : 1.0  initial release
// ============================================================================
module hilo_muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  wire logic               Clk,
  input  wire logic               Reset,
  hilo_muldiv_sequencer_if.slave  bus
);

  localparam int c_CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

  localparam logic [3:0] c_OP_MULT  = 4'd1;
  localparam logic [3:0] c_OP_MULTU = 4'd2;
  localparam logic [3:0] c_OP_DIV   = 4'd3;
  localparam logic [3:0] c_OP_DIVU  = 4'd4;
  localparam logic [3:0] c_OP_MADD  = 4'd5;
  localparam logic [3:0] c_OP_MSUB  = 4'd6;
  localparam logic [3:0] c_OP_MTHI  = 4'd7;
  localparam logic [3:0] c_OP_MTLO  = 4'd8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [c_CW-1:0]    r_cnt;
  logic [3:0]         r_op;
  logic               r_div;       // engine is dividing rather than multiplying
  logic               r_neg;       // product / quotient sign
  logic               r_rneg;      // remainder sign (dividend sign)
  logic               r_zero_div;  // divide op issued with a zero divisor
  logic [WIDTH-1:0]   r_m;         // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] r_acc;       // mult: {partial, multiplier}; div: {rem, quo}
  logic               r_busy;
  logic               r_done;
  logic               r_dbz;

  // Issue decode
  logic               w_accept;
  logic               w_is_arith;
  logic               w_is_div;
  logic               w_is_signed;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;

  // Engine step
  logic [WIDTH:0]     w_msum;
  logic [2*WIDTH-1:0] w_mul_nxt;
  logic [WIDTH:0]     w_trial;
  logic [2*WIDTH-1:0] w_div_nxt;

  // Commit values
  logic [2*WIDTH-1:0] w_prod_s;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [2*WIDTH-1:0] w_hilo;
  logic [2*WIDTH-1:0] w_hilo_madd;
  logic [2*WIDTH-1:0] w_hilo_msub;
  logic [WIDTH-1:0]   w_hi_nxt;
  logic [WIDTH-1:0]   w_lo_nxt;

  // A new op is only taken in IDLE; Busy is low in exactly that state.
  assign w_accept = (r_state == S_IDLE) && bus.Start;

  // Classify the incoming opcode and form operand magnitudes
  always_comb begin
    w_is_arith  = 1'b0;
    w_is_div    = 1'b0;
    w_is_signed = 1'b0;
    case (bus.Op)
      c_OP_MULT:  begin w_is_arith = 1'b1; w_is_signed = 1'b1; end
      c_OP_MULTU: begin w_is_arith = 1'b1; end
      c_OP_DIV:   begin w_is_arith = 1'b1; w_is_div = 1'b1; w_is_signed = 1'b1; end
      c_OP_DIVU:  begin w_is_arith = 1'b1; w_is_div = 1'b1; end
      c_OP_MADD:  begin w_is_arith = 1'b1; w_is_signed = 1'b1; end
      c_OP_MSUB:  begin w_is_arith = 1'b1; w_is_signed = 1'b1; end
      default:    ;
    endcase
    w_a_neg = w_is_signed & bus.OpA[WIDTH-1];
    w_b_neg = w_is_signed & bus.OpB[WIDTH-1];
    // -2^(W-1) maps onto itself, which is the correct unsigned magnitude.
    w_a_mag = w_a_neg ? (~bus.OpA + WIDTH'(1)) : bus.OpA;
    w_b_mag = w_b_neg ? (~bus.OpB + WIDTH'(1)) : bus.OpB;
  end

  // One shift-add or restoring-divide iteration on the accumulator
  always_comb begin
    w_msum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_m} : '0);
    w_mul_nxt = {w_msum, r_acc[WIDTH-1:1]};
    // Shifted remainder needs one extra bit before the trial subtraction.
    w_trial   = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_m};
    if (w_trial[WIDTH])
      w_div_nxt = {r_acc[2*WIDTH-2:0], 1'b0};
    else
      w_div_nxt = {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
  end

  // Sign fix-up of the finished magnitude results and next HI/LO contents
  always_comb begin
    w_prod_s    = r_neg  ? (~r_acc + (2*WIDTH)'(1)) : r_acc;
    w_quo       = r_neg  ? (~r_acc[WIDTH-1:0] + WIDTH'(1)) : r_acc[WIDTH-1:0];
    w_rem       = r_rneg ? (~r_acc[2*WIDTH-1:WIDTH] + WIDTH'(1))
                         : r_acc[2*WIDTH-1:WIDTH];
    w_hilo      = {r_hi, r_lo};
    w_hilo_madd = w_hilo + w_prod_s;
    w_hilo_msub = w_hilo - w_prod_s;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    if (w_accept && (bus.Op == c_OP_MTHI)) w_hi_nxt = bus.OpA;
    if (w_accept && (bus.Op == c_OP_MTLO)) w_lo_nxt = bus.OpA;
    if ((r_state == S_FIX) && !r_zero_div) begin
      case (r_op)
        c_OP_MULT, c_OP_MULTU: {w_hi_nxt, w_lo_nxt} = w_prod_s;
        c_OP_MADD:             {w_hi_nxt, w_lo_nxt} = w_hilo_madd;
        c_OP_MSUB:             {w_hi_nxt, w_lo_nxt} = w_hilo_msub;
        c_OP_DIV, c_OP_DIVU: begin
          w_hi_nxt = w_rem;
          w_lo_nxt = w_quo;
        end
        default: ;
      endcase
    end
  end

  // State register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && w_is_arith) w_state_nxt = S_RUN;
      S_RUN:   if (r_cnt == c_LAST)        w_state_nxt = S_FIX;
      S_FIX:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand capture, engine iteration, HI/LO commit and status flags
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_hi       <= '0;
      r_lo       <= '0;
      r_cnt      <= '0;
      r_op       <= '0;
      r_div      <= 1'b0;
      r_neg      <= 1'b0;
      r_rneg     <= 1'b0;
      r_zero_div <= 1'b0;
      r_m        <= '0;
      r_acc      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_dbz      <= 1'b0;
    end else begin
      r_hi <= w_hi_nxt;
      r_lo <= w_lo_nxt;
      case (r_state)
        S_IDLE: begin
          if (w_accept && w_is_arith) begin
            r_op       <= bus.Op;
            r_div      <= w_is_div;
            r_neg      <= w_a_neg ^ w_b_neg;
            r_rneg     <= w_a_neg;
            r_zero_div <= w_is_div && (bus.OpB == '0);
            r_cnt      <= '0;
            if (w_is_div) begin
              r_m   <= w_b_mag;
              r_acc <= {{WIDTH{1'b0}}, w_a_mag};
            end else begin
              r_m   <= w_a_mag;
              r_acc <= {{WIDTH{1'b0}}, w_b_mag};
            end
          end
        end
        S_RUN: begin
          r_acc <= r_div ? w_div_nxt : w_mul_nxt;
          r_cnt <= r_cnt + c_CW'(1);
        end
        default: ;
      endcase
      r_busy <= (w_state_nxt != S_IDLE);
      r_done <= (r_state == S_FIX);
      r_dbz  <= (r_state == S_FIX) && r_zero_div;
    end
  end

  assign bus.HiLoOut   = bus.HiLoSel ? r_hi : r_lo;
  assign bus.Busy      = r_busy;
  assign bus.Stall     = r_busy & (bus.Start | bus.ReadHiLo);
  assign bus.Done      = r_done;
  assign bus.DivByZero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_hilo_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_hilo_muldiv_sequencer
// Purpose  : Directed, table-driven bench for the HI/LO multiply/divide
//            sequencer plus hand sequences for stall and mid-run reset.
// Revision : 1.0  initial release
// ============================================================================
module tb_hilo_muldiv_sequencer;

  localparam int W = 32;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MADD  = 4'd5;
  localparam logic [3:0] OP_MSUB  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  logic Clk;
  logic Reset;
  int   n_vec  = 0;
  int   n_miss = 0;

  hilo_muldiv_sequencer_if #(.WIDTH(W)) bus ();

  hilo_muldiv_sequencer #(.WIDTH(W)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pre_hi;
    logic [31:0] pre_lo;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic        exp_dbz;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic get_hl(output logic [31:0] hi, output logic [31:0] lo);
    bus.HiLoSel = 1'b1;
    #1 hi = bus.HiLoOut;
    bus.HiLoSel = 1'b0;
    #1 lo = bus.HiLoOut;
  endtask

  // Presents one op for a single edge, then scrambles the operands.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.Start = 1'b1;
    bus.Op    = op;
    bus.OpA   = a;
    bus.OpB   = b;
    tick();
    bus.Start = 1'b0;
    bus.Op    = OP_NOP;
    bus.OpA   = 32'hDEAD_BEEF;
    bus.OpB   = 32'h0BAD_F00D;
  endtask

  // Edges after the start edge until Done is seen, capped at 100.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!bus.Done && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  logic [31:0] hi, lo;
  int          lat;

  initial begin
    bus.Start    = 1'b0;
    bus.Op       = OP_NOP;
    bus.OpA      = '0;
    bus.OpB      = '0;
    bus.ReadHiLo = 1'b0;
    bus.HiLoSel  = 1'b0;

    //               name         op        a             b             pre_hi        pre_lo        exp_hi        exp_lo        dbz
    vq.push_back('{"mult_neg",   OP_MULT,  32'hFFFFFFFE, 32'h00000003, 32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0});
    vq.push_back('{"multu_big",  OP_MULTU, 32'hFFFFFFFE, 32'h00000003, 32'h0,        32'h0,        32'h00000002, 32'hFFFFFFFA, 1'b0});
    vq.push_back('{"multu_max",  OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h0,        32'hFFFFFFFE, 32'h00000001, 1'b0});
    vq.push_back('{"mult_nn",    OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1234,     32'h5678,     32'h00000000, 32'h00000001, 1'b0});
    vq.push_back('{"div_neg",    OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0});
    vq.push_back('{"div_negb",   OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h0,        32'h0,        32'h00000001, 32'hFFFFFFFD, 1'b0});
    vq.push_back('{"div_ovf",    OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h0,        32'h00000000, 32'h80000000, 1'b0});
    vq.push_back('{"divu",       OP_DIVU,  32'd100,      32'd7,        32'h0,        32'h0,        32'h00000002, 32'h0000000E, 1'b0});
    vq.push_back('{"divu_zero",  OP_DIVU,  32'd7,        32'd0,        32'h11111111, 32'h22222222, 32'h11111111, 32'h22222222, 1'b1});
    vq.push_back('{"div_zero",   OP_DIV,   32'd5,        32'd0,        32'h0000AAAA, 32'h0000BBBB, 32'h0000AAAA, 32'h0000BBBB, 1'b1});
    vq.push_back('{"madd_carry", OP_MADD,  32'd1,        32'd1,        32'h0,        32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0});
    vq.push_back('{"msub_borrow",OP_MSUB,  32'd1,        32'd1,        32'h1,        32'h0,        32'h00000000, 32'hFFFFFFFF, 1'b0});
    vq.push_back('{"madd_neg",   OP_MADD,  32'hFFFFFFFE, 32'd3,        32'h0,        32'd10,       32'h00000000, 32'h00000004, 1'b0});
    vq.push_back('{"msub_zero",  OP_MSUB,  32'd2,        32'd3,        32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0});

    // Reset state
    Reset = 1'b1;
    #3 Reset = 1'b0;
    #1;
    get_hl(hi, lo);
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    check("reset_busy", bus.Busy, 0);
    check("reset_done", bus.Done, 0);
    check("reset_dbz", bus.DivByZero, 0);
    repeat (2) @(posedge Clk);
    @(negedge Clk) Reset = 1'b1;

    // MTHI / MTLO single-edge writes
    issue(OP_MTHI, 32'h00000001, 32'h0);
    check("mthi_busy", bus.Busy, 0);
    issue(OP_MTLO, 32'h000FFFFF, 32'h0);
    check("mtlo_busy", bus.Busy, 0);
    check("mtlo_done", bus.Done, 0);
    get_hl(hi, lo);
    check("mthi_val", hi, 32'h00000001);
    check("mtlo_val", lo, 32'h000FFFFF);

    // Table-driven arithmetic vectors
    for (int i = 0; i < vq.size(); i++) begin
      issue(OP_MTHI, vq[i].pre_hi, 32'h0);
      issue(OP_MTLO, vq[i].pre_lo, 32'h0);
      issue(vq[i].op, vq[i].a, vq[i].b);
      check({vq[i].name, "_busy"}, bus.Busy, 1);
      wait_done(lat);
      check({vq[i].name, "_latency"}, lat, 33);
      check({vq[i].name, "_busy_at_done"}, bus.Busy, 0);
      check({vq[i].name, "_dbz"}, bus.DivByZero, vq[i].exp_dbz);
      get_hl(hi, lo);
      check({vq[i].name, "_hi"}, hi, vq[i].exp_hi);
      check({vq[i].name, "_lo"}, lo, vq[i].exp_lo);
      tick();
      check({vq[i].name, "_done_pulse"}, bus.Done, 0);
    end

    // Stall behaviour: reads and starts during a MULT
    issue(OP_MTLO, 32'h00000055, 32'h0);
    issue(OP_MULT, 32'd2, 32'd3);
    repeat (3) tick();
    bus.ReadHiLo = 1'b1;
    #1 check("stall_read", bus.Stall, 1);
    tick();
    bus.ReadHiLo = 1'b0;
    #1 check("stall_idle_req", bus.Stall, 0);
    bus.Start = 1'b1;
    bus.Op    = OP_MTLO;
    bus.OpA   = 32'h00001234;
    #1 check("stall_start", bus.Stall, 1);
    tick();
    check("stall_start_held", bus.Stall, 1);
    wait_done(lat);
    check("stall_done_seen", bus.Done, 1);
    check("stall_at_done", bus.Stall, 0);
    get_hl(hi, lo);
    check("stall_lo_kept", lo, 32'h00000006);
    tick();
    bus.Start = 1'b0;
    bus.Op    = OP_NOP;
    get_hl(hi, lo);
    check("stall_mtlo_taken", lo, 32'h00001234);
    check("stall_mtlo_nobusy", bus.Busy, 0);

    // Reset in the middle of a run
    issue(OP_MTHI, 32'hA5A5A5A5, 32'h0);
    issue(OP_MTLO, 32'h5A5A5A5A, 32'h0);
    issue(OP_MULT, 32'd7, 32'd9);
    repeat (10) tick();
    Reset = 1'b0;
    #1;
    check("midrst_busy", bus.Busy, 0);
    check("midrst_done", bus.Done, 0);
    get_hl(hi, lo);
    check("midrst_hi", hi, 32'h0);
    check("midrst_lo", lo, 32'h0);
    repeat (2) @(posedge Clk);
    @(negedge Clk) Reset = 1'b1;
    tick();
    check("postrst_busy", bus.Busy, 0);
    issue(OP_MULTU, 32'd5, 32'd6);
    wait_done(lat);
    check("postrst_latency", lat, 33);
    get_hl(hi, lo);
    check("postrst_hi", hi, 32'h0);
    check("postrst_lo", lo, 32'h0000001E);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hilo_muldiv_sequencer.md
Name: hilo_muldiv_sequencer

Overview:
Multicycle multiply/divide sequencer that owns the HI/LO register pair for the MIPS datapath. It accepts MULT, MULTU, DIV, DIVU, MADD, MSUB, MTHI and MTLO from the EX stage. It runs a WIDTH-iteration shift-add or restoring-divide engine and commits results to HI/LO. It raises Stall to the hazard unit whenever the pipeline would touch HI/LO while the engine is busy.

Parameters:
WIDTH, 32, operand width and iteration count; HI and LO are each WIDTH bits.

Ports:
Clk  input  1  system clock, rising-edge active
Reset  input  1  asynchronous active-low reset; all state cleared while low
Start  input  1  issue the op on Op with operands OpA/OpB this cycle
Op  input  4  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MADD, 6 MSUB, 7 MTHI, 8 MTLO; 9-15 treated as NOP
OpA  input  WIDTH  rs operand (multiplicand, dividend, or MTHI/MTLO data)
OpB  input  WIDTH  rt operand (multiplier, divisor)
ReadHiLo  input  1  MFHI/MFLO in EX this cycle
HiLoSel  input  1  1 selects HI, 0 selects LO on HiLoOut
HiLoOut  output  WIDTH  combinational: HiLoSel ? HI : LO
Busy  output  1  registered; engine iterating
Stall  output  1  combinational: Busy & (Start | ReadHiLo)
Done  output  1  registered one-cycle pulse at result commit
DivByZero  output  1  registered; pulses with Done when a DIV/DIVU had OpB==0

Behaviour:
- Reset low: HI=0, LO=0, state IDLE, counter 0, Busy=0, Done=0, DivByZero=0. Asynchronous, effective mid-operation; the in-flight op is discarded and HI/LO are not written.
- States: IDLE, RUN, FIX.
- IDLE, rising edge with Start=1, Busy=0:
  - MTHI: HI<=OpA. MTLO: LO<=OpA. Single edge, Busy stays 0, no Done.
  - MULT..MSUB: latch opcode; latch |OpA| and |OpB| for signed ops (raw values for MULTU/DIVU); record result sign. Counter<=0, go to RUN, Busy<=1.
  - NOP/invalid: no effect.
- RUN: one iteration per cycle, counter increments. Multiply is shift-add into a 2*WIDTH accumulator. Divide is restoring, one quotient bit per cycle. After the WIDTH-th iteration (counter==WIDTH-1), go to FIX.
- FIX (one cycle), commit on its exiting edge:
  - MULT/MULTU: {HI,LO} <= product, two's-complement negated if the recorded sign is negative.
  - MADD/MSUB: {HI,LO} <= {HI,LO} +/- signed product, modulo 2^(2*WIDTH).
  - DIV/DIVU: LO <= quotient, HI <= remainder. Signed quotient truncates toward zero; remainder takes the dividend's sign. -2^31 / -1 gives LO=0x80000000, HI=0.
  - Divisor 0: HI/LO unchanged; DivByZero=1 with Done. Full latency is still spent.
  - Then go to IDLE: Busy<=0, Done<=1 for exactly one cycle.
- Latency: the Start edge is E0; Busy is high after E0 through E(WIDTH+1); commit and Done occur at E(WIDTH+1), which is E33 for WIDTH=32. HiLoOut reflects the new value from that cycle.
- Start while Busy: ignored (no latch, no MTHI/MTLO write), Stall=1. The pipeline must hold the instruction and re-present it.
- ReadHiLo while Busy: Stall=1. HiLoOut shows old HI/LO and must not be consumed.
- Start in the same cycle Done=1: accepted normally (Busy already 0). Back-to-back ops therefore need no gap.
- Operands are sampled only at the Start edge; OpA/OpB changes during RUN have no effect.

Test Plan:
1. Reset low for 2 cycles, then high; MTHI 0x00000001 and MTLO 0x000FFFFF -> HiLoOut=0x00000001 with HiLoSel=1 and 0x000FFFFF with HiLoSel=0; Busy stays 0.
2. MULT OpA=0xFFFFFFFE (-2), OpB=0x00000003 -> Busy for 33 cycles, Done at E33; HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
3. DIV OpA=0xFFFFFFF9 (-7), OpB=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/0 -> HI/LO unchanged, DivByZero and Done pulse together.
4. Preload HI=0, LO=0xFFFFFFFF; MADD 1*1 -> HI=1, LO=0 (carry crosses into HI); then MSUB 1*1 -> HI=0, LO=0xFFFFFFFF.
5. During a MULT, assert ReadHiLo and Start(MTLO 0x1234) -> Stall=1 each such cycle; LO is not written by the MTLO; Start(MTLO) re-presented on the Done cycle is accepted.
6. Pull Reset low at RUN counter 10 -> Busy, Done, HI and LO immediately 0; after release, a fresh MULTU 5*6 yields LO=0x0000001E, HI=0.
